stopwatch_core: RTL and testbench

Timekeeping core of the stopwatch: converts the system clock into 0.01 s ticks and keeps a 4-digit BCD count in SS.hh format (00.00 to 99.99). It is controlled by start/stop and clear push-button inputs. It feeds the display path: its four BCD digits are multiplexed onto the 7-segment display, which is scanned by the digit-enable shift register. Digit 1 is rightmost (hundredths); digit 4 is leftmost (tens of seconds).

---
 rtl/stopwatch_core.sv | 192 +++++++++++++++++++
 tb/tb_stopwatch_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: button conditioning, 0.01 s prescaler and SS.hh BCD count.
// Define STOPWATCH_LAP_EN to build the lap (display freeze) feature; the default build omits it.
module stopwatch_core #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startStop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic       running,
  output logic       maxed
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int BTN_LAP = 2;
  localparam int NBTN    = 3;
`else
  localparam int NBTN    = 2;
`endif

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, MAXED} state_e;
  typedef logic [3:0][3:0] bcd4_t;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_meta_q, btn_meta_d;
  logic [NBTN-1:0] btn_sync_q, btn_sync_d;
  logic [NBTN-1:0] btn_prev_q, btn_prev_d;
  logic [NBTN-1:0] btn_pulse;
  logic            ss_pulse, clr_pulse;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  bcd4_t           dig_q, dig_d;
  logic            running_q, running_d;
  logic            maxed_q, maxed_d;
  logic            tick;
  logic            at_max;

`ifdef STOPWATCH_LAP_EN
  assign btn_raw = {lap, clear, startStop};
`else
  assign btn_raw = {clear, startStop};
  logic lap_unused;
  assign lap_unused = lap;
`endif

  // Two-flop synchronizer followed by a one-cycle rising-edge detector per button.
  always_comb begin
    btn_meta_d = btn_raw;
    btn_sync_d = btn_meta_q;
    btn_prev_d = btn_sync_q;
    btn_pulse  = btn_sync_q & ~btn_prev_q;
  end

  assign ss_pulse  = btn_pulse[BTN_SS];
  assign clr_pulse = btn_pulse[BTN_CLR];

  function automatic bcd4_t bcd_inc(input bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick   = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign at_max = (dig_q == {4'd9, 4'd9, 4'd9, 4'd9});

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d = state_q;
    presc_d = presc_q;
    dig_d   = dig_q;

    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (ss_pulse) state_d = RUN;
      end
      RUN: begin
        if (tick && at_max) begin
          state_d = MAXED;
        end else begin
          if (tick) dig_d = bcd_inc(dig_q);
          if (ss_pulse) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (clr_pulse) begin
          state_d = IDLE;
          presc_d = '0;
          dig_d   = '0;
        end else if (ss_pulse) begin
          state_d = RUN;
        end
      end
      MAXED: begin
        if (clr_pulse) begin
          state_d = IDLE;
          presc_d = '0;
          dig_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
    maxed_d   = (state_d == MAXED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      state_q    <= IDLE;
      presc_q    <= '0;
      dig_q      <= '0;
      running_q  <= 1'b0;
      maxed_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      dig_q      <= dig_d;
      running_q  <= running_d;
      maxed_q    <= maxed_d;
    end
  end

  assign running = running_q;
  assign maxed   = maxed_q;

`ifdef STOPWATCH_LAP_EN
  logic  frozen_q, frozen_d;
  bcd4_t disp_q, disp_d;

  // The display copy tracks the next count unless frozen, so release shows the live count at once.
  always_comb begin
    frozen_d = frozen_q;
    if (frozen_q) begin
      if (btn_pulse[BTN_LAP] || clr_pulse || (state_d != RUN)) frozen_d = 1'b0;
    end else if ((state_q == RUN) && (state_d == RUN) && btn_pulse[BTN_LAP]) begin
      frozen_d = 1'b1;
    end
    disp_d = frozen_d ? disp_q : dig_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frozen_q <= 1'b0;
      disp_q   <= '0;
    end else begin
      frozen_q <= frozen_d;
      disp_q   <= disp_d;
    end
  end

  assign {digit4, digit3, digit2, digit1} = disp_q;
`else
  assign {digit4, digit3, digit2, digit1} = dig_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a run-time based reference model predicts every cycle's
// outputs into a queue and a negedge monitor compares them against the DUT.
module tb_stopwatch_core;

  localparam int unsigned CLK_HZ    = 300;
  localparam int unsigned TICK_HZ   = 100;
  localparam int          DIV       = CLK_HZ / TICK_HZ;
  localparam int          MAX_COUNT = 9999;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startStop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic       running, maxed;

  stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .reset(reset), .startStop(startStop), .clear(clear), .lap(lap),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .running(running), .maxed(maxed)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  string phase = "reset";

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h%h.%h%h running=%b maxed=%b, want %h%h.%h%h running=%b maxed=%b",
               name, $time, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic expect_true(input string name, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s @%0t: condition not reached within its cycle budget", name, $time);
    end
  endtask

  function automatic logic [17:0] dut_outs();
    return {digit4, digit3, digit2, digit1, running, maxed};
  endfunction

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_MAXED} mode_e;
  mode_e        m_mode = M_IDLE;
  int           m_run = 0;        // clock cycles spent in RUN since the count was last zeroed
  bit [2:0]     m_prev = '0;      // {lap, clear, startStop} levels at the previous edge
  bit [2:0]     m_rise_q[$];      // rises waiting out the two-edge button latency
  bit           m_frozen = 1'b0;
  int           m_shown = 0;
  logic [17:0]  exp_q[$];

  function automatic int m_count();
    int c;
    c = m_run / DIV;
    return (c > MAX_COUNT) ? MAX_COUNT : c;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_edge();
    bit [2:0] lvl, rise, eff;
    int       old_count;
    mode_e    nm;
    lvl    = {lap, clear, startStop};
    rise   = lvl & ~m_prev;
    m_prev = lvl;
    m_rise_q.push_back(rise);
    eff = '0;
    if (m_rise_q.size() > 2) eff = m_rise_q.pop_front();

    old_count = m_count();
    nm = m_mode;
    case (m_mode)
      M_IDLE:  if (eff[0]) nm = M_RUN;
      M_RUN: begin
        m_run++;
        if (m_run / DIV > MAX_COUNT) nm = M_MAXED;
        else if (eff[0]) nm = M_PAUSE;
      end
      M_PAUSE: begin
        if (eff[1]) begin nm = M_IDLE; m_run = 0; end
        else if (eff[0]) nm = M_RUN;
      end
      M_MAXED: if (eff[1]) begin nm = M_IDLE; m_run = 0; end
      default: nm = M_IDLE;
    endcase
`ifdef STOPWATCH_LAP_EN
    if (m_frozen) begin
      if (eff[2] || eff[1] || nm != M_RUN) m_frozen = 1'b0;
    end else if (m_mode == M_RUN && nm == M_RUN && eff[2]) begin
      m_frozen = 1'b1;
      m_shown  = old_count;
    end
`else
    old_count = old_count;
`endif
    m_mode = nm;
    exp_q.push_back({to_bcd(m_frozen ? m_shown : m_count()), m_mode == M_RUN, m_mode == M_MAXED});
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_mode   = M_IDLE;
      m_run    = 0;
      m_prev   = '0;
      m_frozen = 1'b0;
      m_rise_q.delete();
      exp_q.delete();
    end else begin
      model_edge();
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!reset && exp_q.size() > 0) check(phase, dut_outs(), exp_q.pop_front());
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit ss, input bit cl, input bit lp, input int hold);
    if (ss) startStop = 1'b1;
    if (cl) clear = 1'b1;
    if (lp) lap = 1'b1;
    step(hold);
    startStop = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
    step(1);
  endtask

  // Wait so that a press issued next takes effect when the run time reaches target.
  task automatic run_until(input int target, input string name);
    int n = 0;
    while (m_run + 3 < target && n < 40000) begin
      step(1);
      n++;
    end
    expect_true(name, m_run + 3 >= target);
  endtask

  task automatic reset_pulse();
    #1 reset = 1'b1;
    #1 check("async_reset", dut_outs(), 18'h0);
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    phase = "idle_after_reset";
    step(20);

    phase = "run_and_pause";
    press(1, 0, 0, 2);
    run_until(25 * DIV, "reach_00_25");
    press(1, 0, 0, 3);
    step(100);

    phase = "run_to_12_34";
    press(1, 0, 0, 1);
    begin
      int n = 0;
      while (m_run / DIV < 1234 && n < 40000) begin step(1); n++; end
      expect_true("reach_12_34", m_run / DIV >= 1234);
    end
    reset_pulse();
    phase = "quiet_after_reset";
    step(50);

    phase = "carry_from_09_99";
    press(1, 0, 0, 1);
    run_until(999 * DIV, "reach_09_99");
    press(1, 0, 0, 1);
    step(20);
    press(1, 0, 0, 4);
    step(30);

    phase = "run_to_max";
    begin
      int n = 0;
      while (m_mode != M_MAXED && n < 40000) begin step(1); n++; end
      expect_true("reach_maxed", m_mode == M_MAXED);
    end
    step(10);
    phase = "maxed_ignores_start";
    press(1, 0, 0, 2);
    step(20);
    phase = "maxed_clear";
    press(0, 1, 0, 2);
    step(10);

    phase = "pause_clear_race";
    press(1, 0, 0, 1);
    run_until(50 * DIV, "reach_00_50");
    press(1, 0, 0, 1);
    step(10);
    press(1, 1, 0, 1);
    step(10);

    phase = "idle_start_clear_race";
    press(1, 1, 0, 1);
    step(30);
    phase = "clear_in_run";
    press(0, 1, 0, 2);
    step(30);
    press(1, 0, 0, 1);
    step(5);
    press(0, 1, 0, 1);
    step(10);

    phase = "lap";
    press(1, 0, 0, 1);
    begin
      int n = 0;
      while ((m_run + 2) / DIV < 100 && n < 40000) begin step(1); n++; end
      expect_true("reach_01_00", (m_run + 2) / DIV >= 100);
    end
    press(0, 0, 1, 2);
    step(297);
    press(0, 0, 1, 1);
    step(20);
    press(1, 0, 0, 1);
    step(5);
    press(0, 1, 0, 1);
    step(10);

    phase = "random";
    repeat (300) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 9)       press(1, 0, 0, $urandom_range(1, 6));
      else if (sel < 13) press(0, 1, 0, $urandom_range(1, 6));
      else if (sel < 16) press(0, 0, 1, $urandom_range(1, 6));
      else if (sel < 18) press(1, 1, 0, $urandom_range(1, 3));
      else if (sel < 19) press(1, 0, 1, $urandom_range(1, 3));
      else               reset_pulse();
      step($urandom_range(0, 60));
    end

    phase = "done";
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
